// File: rtl/dlx_pkg.sv
// dlx_pkg: types and constants shared by the DLX fetch path.
//   fault_e   : classification returned with every fetch response
//   NOP_INSTR : word returned in place of RAM data for a faulted fetch
//   instr_t   : instruction word type
package dlx_pkg;

    typedef enum logic [1:0] {
        F_OK           = 2'b00,
        F_MISALIGNED   = 2'b01,
        F_OUT_OF_RANGE = 2'b10
    } fault_e;

    typedef logic [31:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-clock word RAM with one registered read port and one
// write port. The read register holds its value when re is low.
// A read and a write to the same word in one cycle return the old word.
// Ports:
//   clk, reset  : clock; synchronous active-high reset (clears rdata only)
//   re, raddr   : read enable and word index; rdata valid the next cycle
//   rdata       : registered read data
//   we, waddr,  : write enable, word index and data, committed at the edge
//   wdata
module imem_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // mem is read here before the nonblocking write below lands, which
    // gives read-before-write on a same-word collision.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Contents deliberately survive reset so a loaded program stays put.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory side of the fetch interface.
// A fetch accepted in cycle N returns in cycle N+LATENCY; one fetch per cycle.
// Ports:
//   clk, reset          : clock; synchronous active-high reset
//   IF, i_address       : fetch strobe and byte address
//   flush               : PC redirect, kills every in-flight fetch
//   stall               : decode not ready, freezes pipeline and outputs
//   ready               : fetch accepted this cycle when IF && ready
//   i_data, i_valid,    : response word, valid strobe and fault code
//   i_fault
//   prog_we, prog_addr, : program-load write port (byte address, word data)
//   prog_data
//
// Handshake: a request transfers on any cycle where IF && ready; ready is
// low in reset and while stall is high. The response side has no ready of
// its own: stall is the back-pressure, and while it is high i_valid/i_data/
// i_fault are held, so a held i_valid=1 is the same response, not a new one.
module imem_responder
    import dlx_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IF,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              flush,
    input  logic              stall,
    output logic              ready,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    output fault_e            i_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * DEPTH_WORDS);

    logic   accept;
    fault_e req_fault;
    logic   ram_re;
    logic   ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] head_data;

    // Stage 0: valid/fault travel beside the RAM read register.
    logic   s0_valid_d, s0_valid_q;
    fault_e s0_fault_d, s0_fault_q;

    assign ready  = !reset && !stall;
    assign accept = IF && ready;

    always_comb begin
        req_fault = F_OK;
        if (i_address[1:0] != 2'b00) begin
            req_fault = F_MISALIGNED;
        end else if (i_address >= MEM_BYTES) begin
            req_fault = F_OUT_OF_RANGE;
        end
    end

    // Faulted fetches never touch the RAM; its read register keeps old data.
    assign ram_re = accept && (req_fault == F_OK);
    assign ram_we = prog_we && (prog_addr < MEM_BYTES);

    imem_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .re    (ram_re),
        .raddr (i_address[2 +: AW]),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (prog_addr[2 +: AW]),
        .wdata (prog_data)
    );

    // A fetch accepted together with flush is the redirect target and
    // survives; flush wins over stall for everything already in flight.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_fault_d = s0_fault_q;
        if (flush || !stall) begin
            s0_valid_d = accept;
        end
        if (accept) begin
            s0_fault_d = req_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_fault_q <= F_OK;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_fault_q <= s0_fault_d;
        end
    end

    // s0_fault_q only changes on accept, so this holds across bubbles too.
    assign head_data = (s0_fault_q == F_OK) ? ram_rdata : DATA_W'(NOP_INSTR);

    if (LATENCY == 1) begin : g_direct
        assign i_valid = s0_valid_q;
        assign i_fault = s0_fault_q;
        assign i_data  = head_data;
    end else begin : g_pipe
        logic [LATENCY-2:0]             vld_d, vld_q;
        logic [LATENCY-2:0][1:0]        flt_d, flt_q;
        logic [LATENCY-2:0][DATA_W-1:0] dat_d, dat_q;

        // src_*[k] is what feeds stage k; the top entry is the output stage.
        logic [LATENCY-1:0]             src_valid;
        logic [LATENCY-1:0][1:0]        src_fault;
        logic [LATENCY-1:0][DATA_W-1:0] src_data;

        assign src_valid = {vld_q, s0_valid_q};
        assign src_fault = {flt_q, s0_fault_q};
        assign src_data  = {dat_q, head_data};

        // Payload only loads behind a valid entry so bubbles keep last data.
        always_comb begin
            vld_d = vld_q;
            flt_d = flt_q;
            dat_d = dat_q;
            for (int k = 0; k < LATENCY - 1; k++) begin
                if (flush) begin
                    vld_d[k] = 1'b0;
                end else if (!stall) begin
                    vld_d[k] = src_valid[k];
                    if (src_valid[k]) begin
                        flt_d[k] = src_fault[k];
                        dat_d[k] = src_data[k];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                flt_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                flt_q <= flt_d;
                dat_q <= dat_d;
            end
        end

        assign i_valid = src_valid[LATENCY-1];
        assign i_fault = fault_e'(src_fault[LATENCY-1]);
        assign i_data  = src_data[LATENCY-1];
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder. Main instance uses LATENCY=2; a second
// LATENCY=3 instance on the same inputs checks a flush that lands while
// both earlier fetches are still inside the pipeline.
module tb_imem_responder;

    // ---------------- clock / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, flush, stall, prog_we;
    logic [31:0] i_address, prog_addr, prog_data;
    logic        ready, i_valid;
    logic [31:0] i_data;
    logic [1:0]  i_fault;
    logic        ready3, i_valid3;
    logic [31:0] i_data3;
    logic [1:0]  i_fault3;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    imem_responder dut (
        .clk(clk), .reset(reset), .IF(if_req), .i_address(i_address),
        .flush(flush), .stall(stall), .ready(ready), .i_data(i_data),
        .i_valid(i_valid), .i_fault(i_fault), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .IF(if_req), .i_address(i_address),
        .flush(flush), .stall(stall), .ready(ready3), .i_data(i_data3),
        .i_valid(i_valid3), .i_fault(i_fault3), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req    = 1'b1;
        i_address = a;
    endtask

    task automatic idle();
        if_req = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; if_req = 1'b1; i_address = 32'h0;
        flush = 1'b0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = 32'h0; prog_data = 32'h0;

        // Reset held 3 cycles with IF high
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_ready", {31'b0, ready}, 32'd0);
            chk("rst_valid", {31'b0, i_valid}, 32'd0);
        end
        reset = 1'b0;
        idle();
        settle();
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_valid", {31'b0, i_valid}, 32'd0);
        chk("post_rst_data", i_data, 32'h0);
        chk("post_rst_fault", {30'b0, i_fault}, 32'd0);

        // Program load; the 0x1000 write is out of range and must not alias word 0
        write(32'h0, 32'hA0); cyc();
        write(32'h4, 32'hA1); cyc();
        write(32'h8, 32'hA2); cyc();
        write(32'hC, 32'hA3); cyc();
        write(32'h20, 32'hB8); cyc();
        write(32'h1000, 32'hDEAD_BEEF); cyc();
        prog_we = 1'b0;

        // Streaming 0,4,8,12 back to back
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) fetch(32'(4 * i)); else idle();
            settle();
            if (i < 2) begin
                chk("stream_lead_valid", {31'b0, i_valid}, 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                chk("stream_valid", {31'b0, i_valid}, 32'd1);
                chk("stream_data", i_data, exp_w);
                chk("stream_fault", {30'b0, i_fault}, 32'd0);
            end
            cyc();
        end
        chk("stream_bubble_valid", {31'b0, i_valid}, 32'd0);
        chk("stream_bubble_hold", i_data, 32'hA3);

        // Faults: misaligned then out of range
        fetch(32'h6); cyc();
        fetch(32'h1000); cyc();
        idle(); settle();
        chk("mis_valid", {31'b0, i_valid}, 32'd1);
        chk("mis_fault", {30'b0, i_fault}, 32'd1);
        chk("mis_data", i_data, 32'h0);
        cyc();
        chk("oor_valid", {31'b0, i_valid}, 32'd1);
        chk("oor_fault", {30'b0, i_fault}, 32'd2);
        chk("oor_data", i_data, 32'h0);
        cyc();
        chk("fault_tail_valid", {31'b0, i_valid}, 32'd0);

        // Stall for 3 cycles after the first response; IF stays high meanwhile
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1); exp_q.push_back(32'hA2);
        fetch(32'h0); cyc();
        fetch(32'h4); cyc();
        fetch(32'h8); settle();
        exp_w = exp_q.pop_front();
        chk("stall_first_data", i_data, exp_w);
        cyc();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            fetch(32'hC);
            settle();
            chk("stall_ready", {31'b0, ready}, 32'd0);
            chk("stall_valid", {31'b0, i_valid}, 32'd1);
            chk("stall_data", i_data, exp_q[0]);
            cyc();
        end
        stall = 1'b0;
        idle(); settle();
        chk("unstall_ready", {31'b0, ready}, 32'd1);
        exp_w = exp_q.pop_front();
        chk("unstall_valid", {31'b0, i_valid}, 32'd1);
        chk("unstall_data", i_data, exp_w);
        cyc();
        exp_w = exp_q.pop_front();
        chk("unstall_next_valid", {31'b0, i_valid}, 32'd1);
        chk("unstall_next_data", i_data, exp_w);
        cyc();
        chk("unstall_end_valid", {31'b0, i_valid}, 32'd0);
        cyc();
        chk("stall_no_extra", {31'b0, i_valid}, 32'd0);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Flush: fetch 0,4 then flush together with a fetch of 0x20
        fetch(32'h0); cyc();
        fetch(32'h4); cyc();
        flush = 1'b1;
        fetch(32'h20); settle();
        chk("flush3_pre_valid", {31'b0, i_valid3}, 32'd0);
        cyc();
        flush = 1'b0;
        idle(); settle();
        chk("flush_killed4_valid", {31'b0, i_valid}, 32'd0);
        chk("flush3_killed0_valid", {31'b0, i_valid3}, 32'd0);
        cyc();
        chk("flush_target_valid", {31'b0, i_valid}, 32'd1);
        chk("flush_target_data", i_data, 32'hB8);
        chk("flush3_killed4_valid", {31'b0, i_valid3}, 32'd0);
        cyc();
        chk("flush_tail_valid", {31'b0, i_valid}, 32'd0);
        chk("flush3_target_valid", {31'b0, i_valid3}, 32'd1);
        chk("flush3_target_data", i_data3, 32'hB8);
        cyc();
        chk("flush3_tail_valid", {31'b0, i_valid3}, 32'd0);

        // Reset in the middle of a fetch discards it
        fetch(32'h4); cyc();
        reset = 1'b1;
        idle(); cyc();
        reset = 1'b0;
        settle();
        chk("midrst_valid", {31'b0, i_valid}, 32'd0);
        chk("midrst_data", i_data, 32'h0);
        cyc();
        chk("midrst_valid_after", {31'b0, i_valid}, 32'd0);
        chk("midrst3_valid_after", {31'b0, i_valid3}, 32'd0);

        // Write/fetch collision on word 2
        write(32'h8, 32'h11); cyc();
        write(32'h8, 32'h22);
        fetch(32'h8); cyc();
        prog_we = 1'b0;
        fetch(32'h8); cyc();
        idle(); settle();
        chk("collide_old_valid", {31'b0, i_valid}, 32'd1);
        chk("collide_old_data", i_data, 32'h11);
        cyc();
        chk("collide_new_valid", {31'b0, i_valid}, 32'd1);
        chk("collide_new_data", i_data, 32'h22);
        cyc();

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
